// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : MIPS IF stage: PC, instruction SRAM request, stall-safe IF->ID hand-off.
// Revision : 1.0
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          STALL_WD    = 6,
  parameter int          BR_WD       = 33,
  parameter int          IF_TO_ID_WD = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [31:0]            inst_o,
  output logic                   fetch_adel
);

  typedef enum logic {
    HOLD_IDLE = 1'b0,
    HOLD_FULL = 1'b1
  } hold_state_t;

  logic                   br_e;
  logic [31:0]            br_addr;
  logic [31:0]            pc_reg;
  logic [31:0]            next_pc;
  logic                   ce_reg;
  logic                   br_pending;
  logic [31:0]            br_target;
  logic                   rd_valid;
  logic [31:0]            hold_reg;
  hold_state_t            hold_state;
  logic [IF_TO_ID_WD-1:0] id_bus_reg;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // Only the IF and ID stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall[STALL_WD-1:2]};

  always_comb begin
    if (br_e) begin
      next_pc = br_addr;
    end else if (br_pending) begin
      next_pc = br_target;
    end else begin
      next_pc = pc_reg + 32'd4;
    end
  end

  assign fetch_adel      = ce_reg & (pc_reg[1:0] != 2'b00);
  assign inst_sram_en    = ce_reg & ~stall[0] & ~fetch_adel;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;
  assign if_to_id_bus    = id_bus_reg;

  // Without a live read (reset, misaligned slot) ID is handed a nop.
  assign inst_o = (hold_state == HOLD_FULL) ? hold_reg
                : (rd_valid ? inst_sram_rdata : 32'h0000_0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_PC - 32'd4;
      ce_reg     <= 1'b0;
      br_pending <= 1'b0;
      br_target  <= 32'h0000_0000;
      rd_valid   <= 1'b0;
      hold_reg   <= 32'h0000_0000;
      hold_state <= HOLD_IDLE;
      id_bus_reg <= '0;
    end else begin
      ce_reg   <= 1'b1;
      rd_valid <= inst_sram_en;

      if (!stall[0]) begin
        pc_reg     <= next_pc;
        br_pending <= 1'b0;
        id_bus_reg <= {ce_reg, pc_reg};
      end else if (br_e) begin
        // Redirect arrives while IF is frozen: remember it for the release edge.
        br_pending <= 1'b1;
        br_target  <= br_addr;
      end

      case (hold_state)
        HOLD_IDLE: begin
          if (rd_valid && stall[1]) begin
            hold_reg   <= inst_sram_rdata;
            hold_state <= HOLD_FULL;
          end
        end
        HOLD_FULL: begin
          if (!stall[1]) begin
            hold_state <= HOLD_IDLE;
          end
        end
        default: hold_state <= HOLD_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
